// File: rtl/df_join_pkg.sv
// df_join_pkg
// Shared defaults and sizing helpers for the df_join slice.
// Nothing here is a port; it only feeds parameter defaults and derived widths
// to join_fifo and df_join.
package df_join_pkg;

    localparam int DEFAULT_PRECISION   = 16;
    localparam int DEFAULT_PARALLELISM = 4;
    localparam int DEFAULT_FIFO_DEPTH  = 4;

    // Occupancy needs one more bit than a pointer so "full" (== depth) is representable.
    function automatic int count_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/join_fifo.sv
// join_fifo
// Small circular buffer holding whole beats (COUNT elements of WIDTH bits).
// Ports:
//   clk, rst   - rising-edge clock, synchronous active-high reset
//   push       - write push_data this cycle (ignored when full)
//   push_data  - beat to store
//   pop        - drop the head entry this cycle (ignored when empty)
//   head       - oldest stored beat (stale or zero when empty)
//   count      - current occupancy, 0..DEPTH
module join_fifo
    import df_join_pkg::*;
#(
    parameter int  WIDTH = DEFAULT_PRECISION,
    parameter int  COUNT = DEFAULT_PARALLELISM,
    parameter int  DEPTH = DEFAULT_FIFO_DEPTH,
    localparam int CNT_W = count_width(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data [COUNT],
    input  logic             pop,
    output logic [WIDTH-1:0] head [COUNT],
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH][COUNT];
    logic             do_push;
    logic             do_pop;

    // Guard locally so a caller mistake can never overrun or underrun the buffer.
    assign do_push = push && (count != CNT_W'(DEPTH));
    assign do_pop  = pop  && (count != '0);

    // DEPTH is a power of two, so pointers wrap by natural overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                for (int j = 0; j < COUNT; j++) begin
                    mem[i][j] <= '0;
                end
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_comb begin
        head = mem[rd_ptr];
    end

endmodule

// File: rtl/df_join.sv
// df_join
// Joins two valid/ready streams: one output beat pairs the i-th accepted beat
// of branch 0 with the i-th accepted beat of branch 1. Each branch is buffered
// independently so skew of up to FIFO_DEPTH beats costs no input stall.
// Ports:
//   clk, rst                          - rising-edge clock, synchronous active-high reset
//   data_in_0, _valid, _ready         - branch-0 input stream
//   data_in_1, _valid, _ready         - branch-1 input stream
//   data_out_0, data_out_1            - paired head beats of the two buffers
//   data_out_valid, data_out_ready    - joined output handshake
module df_join
    import df_join_pkg::*;
#(
    parameter int  DATA_IN_0_PRECISION_0       = DEFAULT_PRECISION,
    parameter int  DATA_IN_1_PRECISION_0       = DEFAULT_PRECISION,
    parameter int  DATA_IN_0_PARALLELISM_DIM_0 = DEFAULT_PARALLELISM,
    parameter int  DATA_IN_0_PARALLELISM_DIM_1 = 1,
    parameter int  DATA_IN_1_PARALLELISM_DIM_0 = DEFAULT_PARALLELISM,
    parameter int  DATA_IN_1_PARALLELISM_DIM_1 = 1,
    parameter int  FIFO_DEPTH                  = DEFAULT_FIFO_DEPTH,
    localparam int N0 = DATA_IN_0_PARALLELISM_DIM_0 * DATA_IN_0_PARALLELISM_DIM_1,
    localparam int N1 = DATA_IN_1_PARALLELISM_DIM_0 * DATA_IN_1_PARALLELISM_DIM_1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [DATA_IN_0_PRECISION_0-1:0] data_in_0 [N0],
    input  logic                             data_in_0_valid,
    output logic                             data_in_0_ready,
    input  logic [DATA_IN_1_PRECISION_0-1:0] data_in_1 [N1],
    input  logic                             data_in_1_valid,
    output logic                             data_in_1_ready,
    output logic [DATA_IN_0_PRECISION_0-1:0] data_out_0 [N0],
    output logic [DATA_IN_1_PRECISION_0-1:0] data_out_1 [N1],
    output logic                             data_out_valid,
    input  logic                             data_out_ready
);

    localparam int CNT_W = count_width(FIFO_DEPTH);

    logic [CNT_W-1:0] count_0;
    logic [CNT_W-1:0] count_1;
    logic             push_0;
    logic             push_1;
    logic             pop;

    // Ready depends only on stored occupancy, never on data_out_ready, so a
    // full buffer refuses input even in a cycle where it is being popped.
    assign data_in_0_ready = (count_0 < CNT_W'(FIFO_DEPTH));
    assign data_in_1_ready = (count_1 < CNT_W'(FIFO_DEPTH));
    assign push_0          = data_in_0_valid && data_in_0_ready;
    assign push_1          = data_in_1_valid && data_in_1_ready;

    // Output is only offered when both heads exist; a fire pops both together.
    assign data_out_valid = (count_0 != '0) && (count_1 != '0);
    assign pop            = data_out_valid && data_out_ready;

    join_fifo #(
        .WIDTH (DATA_IN_0_PRECISION_0),
        .COUNT (N0),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo_0 (
        .clk       (clk),
        .rst       (rst),
        .push      (push_0),
        .push_data (data_in_0),
        .pop       (pop),
        .head      (data_out_0),
        .count     (count_0)
    );

    join_fifo #(
        .WIDTH (DATA_IN_1_PRECISION_0),
        .COUNT (N1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo_1 (
        .clk       (clk),
        .rst       (rst),
        .push      (push_1),
        .push_data (data_in_1),
        .pop       (pop),
        .head      (data_out_1),
        .count     (count_1)
    );

endmodule

// File: tb/tb_df_join.sv
// tb_df_join
// Self-checking bench for df_join: a queue-based model of the two branch
// buffers is checked against the DUT every cycle, plus literal expectations
// for the directed scenarios.
module tb_df_join;

    localparam int W = 16;
    localparam int N = 4;
    localparam int D = 4;

    typedef logic [N*W-1:0] beat_t;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] data_in_0 [N];
    logic         data_in_0_valid;
    logic         data_in_0_ready;
    logic [W-1:0] data_in_1 [N];
    logic         data_in_1_valid;
    logic         data_in_1_ready;
    logic [W-1:0] data_out_0 [N];
    logic [W-1:0] data_out_1 [N];
    logic         data_out_valid;
    logic         data_out_ready;

    beat_t q0[$];
    beat_t q1[$];
    int    total   = 0;
    int    bad     = 0;
    bit    started = 1'b0;

    df_join dut (
        .clk             (clk),
        .rst             (rst),
        .data_in_0       (data_in_0),
        .data_in_0_valid (data_in_0_valid),
        .data_in_0_ready (data_in_0_ready),
        .data_in_1       (data_in_1),
        .data_in_1_valid (data_in_1_valid),
        .data_in_1_ready (data_in_1_ready),
        .data_out_0      (data_out_0),
        .data_out_1      (data_out_1),
        .data_out_valid  (data_out_valid),
        .data_out_ready  (data_out_ready)
    );

    always #5 clk = ~clk;

    function automatic beat_t pack_beat(input logic [W-1:0] d [N]);
        beat_t r;
        for (int e = 0; e < N; e++) r[e*W +: W] = d[e];
        return r;
    endfunction

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Element e of a beat carries the beat tag in its low bits and e in the top nibble.
    task automatic set_in0(input logic [15:0] v);
        for (int e = 0; e < N; e++) data_in_0[e] = v | (16'(e) << 12);
    endtask

    task automatic set_in1(input logic [15:0] v);
        for (int e = 0; e < N; e++) data_in_1[e] = v | (16'(e) << 12);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Model: each branch is a FIFO of whole beats; an output pair exists whenever
    // both FIFOs are non-empty, and input acceptance depends only on fill level.
    always @(posedge clk) begin
        bit p, a0, a1;
        if (rst) begin
            q0.delete();
            q1.delete();
            started = 1'b1;
        end else if (started) begin
            p  = (q0.size() > 0) && (q1.size() > 0) && data_out_ready;
            a0 = data_in_0_valid && (q0.size() < D);
            a1 = data_in_1_valid && (q1.size() < D);
            if (p) begin
                void'(q0.pop_front());
                void'(q1.pop_front());
            end
            if (a0) q0.push_back(pack_beat(data_in_0));
            if (a1) q1.push_back(pack_beat(data_in_1));
        end
    end

    // Compare DUT against the model on the falling edge, away from the active edge.
    always @(negedge clk) begin
        bit mv;
        if (started && !rst) begin
            mv = (q0.size() > 0) && (q1.size() > 0);
            check_output("out_valid", data_out_valid, mv);
            check_output("in0_ready", data_in_0_ready, q0.size() < D);
            check_output("in1_ready", data_in_1_ready, q1.size() < D);
            if (mv) begin
                check_output("out0_data", pack_beat(data_out_0), q0[0]);
                check_output("out1_data", pack_beat(data_out_1), q1[0]);
            end
        end
    end

    task automatic apply_stimulus();
        int  s0, s1, cyc;
        bit  a0, a1;

        // Reset and idle state.
        rst = 1'b1;
        data_in_0_valid = 1'b0;
        data_in_1_valid = 1'b0;
        data_out_ready  = 1'b0;
        set_in0(16'h0);
        set_in1(16'h0);
        step();
        step();
        rst = 1'b0;
        check_output("rst_valid", data_out_valid, 1'b0);
        check_output("rst_ready0", data_in_0_ready, 1'b1);
        check_output("rst_ready1", data_in_1_ready, 1'b1);
        check_output("rst_out0", pack_beat(data_out_0), 64'h0);
        check_output("rst_out1", pack_beat(data_out_1), 64'h0);

        // Lockstep streaming.
        data_out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            data_in_0_valid = 1'b1;
            data_in_1_valid = 1'b1;
            set_in0(16'(i));
            set_in1(16'(i));
            step();
            if (i == 1) begin
                check_output("lock_first_valid", data_out_valid, 1'b1);
                check_output("lock_first_out0", data_out_0[0], 16'h0001);
                check_output("lock_first_out1", data_out_1[0], 16'h0001);
            end
        end
        data_in_0_valid = 1'b0;
        data_in_1_valid = 1'b0;
        repeat (3) step();
        check_output("lock_drained", data_out_valid, 1'b0);

        // Skew: branch 0 runs ahead by a full buffer.
        for (int i = 0; i < 4; i++) begin
            data_in_0_valid = 1'b1;
            set_in0(16'h00A0 + 16'(i));
            step();
        end
        data_in_0_valid = 1'b0;
        check_output("skew_ready0_low", data_in_0_ready, 1'b0);
        check_output("skew_valid_low", data_out_valid, 1'b0);
        for (int i = 0; i < 4; i++) begin
            data_in_1_valid = 1'b1;
            set_in1(16'h00B0 + 16'(i));
            step();
            if (i == 0) begin
                check_output("skew_pair_out0", data_out_0[0], 16'h00A0);
                check_output("skew_pair_out1", data_out_1[0], 16'h00B0);
            end
        end
        data_in_1_valid = 1'b0;
        repeat (3) step();

        // Back-pressure: ten stalled cycles, exactly four beats fit per branch.
        data_out_ready = 1'b0;
        for (int c = 0; c < 10; c++) begin
            data_in_0_valid = 1'b1;
            data_in_1_valid = 1'b1;
            set_in0(c < 4 ? 16'(c + 1) : 16'd5);
            set_in1(c < 4 ? 16'(c + 1) : 16'd5);
            step();
            check_output("bp_hold_out0", data_out_0[0], 16'h0001);
        end
        check_output("bp_ready0_low", data_in_0_ready, 1'b0);
        check_output("bp_ready1_low", data_in_1_ready, 1'b0);

        // Full plus pop: no acceptance in the pop cycle, ready returns next cycle.
        data_out_ready = 1'b1;
        step();
        check_output("fp_ready0_back", data_in_0_ready, 1'b1);
        check_output("fp_ready1_back", data_in_1_ready, 1'b1);
        check_output("fp_head_out0", data_out_0[0], 16'h0002);
        step();
        data_in_0_valid = 1'b0;
        data_in_1_valid = 1'b0;
        repeat (6) step();
        check_output("bp_drained", data_out_valid, 1'b0);

        // Wrap-around with random gaps and random output ready.
        s0 = 0; s1 = 0; cyc = 0; a0 = 1'b0; a1 = 1'b0;
        while (!(s0 == 20 && s1 == 20 && q0.size() == 0 && q1.size() == 0) && cyc < 500) begin
            if (s0 >= 20) data_in_0_valid = 1'b0;
            else if (!data_in_0_valid || a0) data_in_0_valid = ($urandom_range(0, 2) != 0);
            if (s1 >= 20) data_in_1_valid = 1'b0;
            else if (!data_in_1_valid || a1) data_in_1_valid = ($urandom_range(0, 2) != 0);
            set_in0(16'h0C00 + 16'(s0));
            set_in1(16'h0D00 + 16'(s1));
            data_out_ready = ($urandom_range(0, 1) != 0);
            a0 = data_in_0_valid && data_in_0_ready;
            a1 = data_in_1_valid && data_in_1_ready;
            step();
            if (a0) s0++;
            if (a1) s1++;
            cyc++;
        end
        data_in_0_valid = 1'b0;
        data_in_1_valid = 1'b0;
        check_output("wrap_drained", (s0 == 20 && s1 == 20 && q0.size() == 0 && q1.size() == 0), 1'b1);

        // Reset mid-stream with three beats buffered and a handshake in flight.
        data_out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            data_in_0_valid = 1'b1;
            data_in_1_valid = 1'b1;
            set_in0(16'h0021 + 16'(i));
            set_in1(16'h0021 + 16'(i));
            step();
        end
        set_in0(16'h0024);
        set_in1(16'h0024);
        rst = 1'b1;
        step();
        rst = 1'b0;
        data_in_0_valid = 1'b0;
        data_in_1_valid = 1'b0;
        check_output("mid_rst_valid", data_out_valid, 1'b0);
        check_output("mid_rst_out0", pack_beat(data_out_0), 64'h0);
        check_output("mid_rst_out1", pack_beat(data_out_1), 64'h0);
        check_output("mid_rst_ready0", data_in_0_ready, 1'b1);
        check_output("mid_rst_ready1", data_in_1_ready, 1'b1);
        data_out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            data_in_0_valid = 1'b1;
            data_in_1_valid = 1'b1;
            set_in0(16'h0031 + 16'(i));
            set_in1(16'h0031 + 16'(i));
            step();
            if (i == 0) begin
                check_output("post_rst_out0", data_out_0[0], 16'h0031);
                check_output("post_rst_out1", data_out_1[0], 16'h0031);
            end
        end
        data_in_0_valid = 1'b0;
        data_in_1_valid = 1'b0;
        repeat (3) step();
    endtask

    initial begin
        apply_stimulus();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/df_join.md
DF_JOIN -- requirements
Module: df_join

Interface
REQ-001 Parameter DATA_IN_0_PRECISION_0, 16, bit width of each element on input 0.
REQ-002 Parameter DATA_IN_1_PRECISION_0, 16, bit width of each element on input 1.
REQ-003 Parameter DATA_IN_0_PARALLELISM_DIM_0 / _DIM_1, 4 / 1, elements per beat on input 0; N0 = DIM_0*DIM_1.
REQ-004 Parameter DATA_IN_1_PARALLELISM_DIM_0 / _DIM_1, 4 / 1, elements per beat on input 1; N1 = DIM_0*DIM_1.
REQ-005 Parameter FIFO_DEPTH, 4, entries per input buffer; legal values are powers of two and at least 2.
REQ-006 Port clk, input, 1, the single clock; all logic is rising-edge.
REQ-007 Port rst, input, 1, reset: synchronous and active-high.
REQ-008 Port data_in_0, input, [DATA_IN_0_PRECISION_0] x N0 unpacked array, branch-0 beat.
REQ-009 Port data_in_0_valid / data_in_0_ready, input / output, 1 / 1, branch-0 handshake.
REQ-010 Port data_in_1, input, [DATA_IN_1_PRECISION_0] x N1 unpacked array, branch-1 beat.
REQ-011 Port data_in_1_valid / data_in_1_ready, input / output, 1 / 1, branch-1 handshake.
REQ-012 Port data_out_0, output, same shape as data_in_0, paired beat from branch 0.
REQ-013 Port data_out_1, output, same shape as data_in_1, paired beat from branch 1.
REQ-014 Port data_out_valid / data_out_ready, output / input, 1 / 1, single joined handshake.

Function
REQ-015 A beat transfers on an interface only in a cycle where valid and ready are both high at the clk edge.
REQ-016 Each input SHALL own an independent FIFO_DEPTH-entry buffer with a write pointer, a read pointer and an occupancy count of width clog2(FIFO_DEPTH)+1.
REQ-017 data_in_k_ready = (count_k < FIFO_DEPTH), a registered-state function; it is not a function of data_out_ready, so a full buffer cannot accept in the same cycle as a pop.
REQ-018 data_out_valid = (count_0 != 0) && (count_1 != 0).
REQ-019 data_out_0 and data_out_1 are driven from the head entries of buffer 0 and buffer 1, so the beats presented together are the i-th accepted beat of each branch.
REQ-020 An output fire pops exactly one entry from each buffer; a partial pop is never permitted.
REQ-021 Latency: a beat accepted at edge t is visible on the outputs from cycle t+1 at the earliest, provided the other branch holds data; no combinational path exists from data_in_* to data_out_*.
REQ-022 A simultaneous push and pop on one buffer leaves count unchanged and advances both pointers.
REQ-023 Pointers wrap modulo FIFO_DEPTH.
REQ-024 While data_out_valid is high and data_out_ready is low, data_out_0 and data_out_1 SHALL hold stable.
REQ-025 Branch skew of up to FIFO_DEPTH beats SHALL be absorbed without any input stall; beyond that skew, only the leading branch is back-pressured.
REQ-026 Element data is passed bit-exact, with no arithmetic, reordering or width change.

Reset
REQ-027 With rst high at an edge, all counts and pointers are cleared to 0 and all storage is cleared to 0.
REQ-028 After reset: data_out_valid = 0, data_out_0 = data_out_1 = all zeros, data_in_0_ready = data_in_1_ready = 1.
REQ-029 Reset asserted mid-operation discards all buffered beats, and any handshake in that same cycle is ignored.

Structure
REQ-030 No shared package types are required; depth and pointer-width constants are local parameters derived from FIFO_DEPTH.
REQ-031 Each buffer is one instance of a single sub-module, join_fifo, parameterised by element width, element count and depth, exposing push/pop/count/head.
REQ-032 df_join contains only the two join_fifo instances plus the join valid and pop logic.

Verification
REQ-033 Lockstep: both inputs drive beats 0x0001..0x0008 every cycle with data_out_ready=1 -> 8 outputs with data_out_0 equal to data_out_1 in order, and inputs never stalled.
REQ-034 Skew: input 0 sends 4 beats (0xA0..0xA3) and input 1 sends nothing -> data_out_valid stays 0 and data_in_0_ready drops after the 4th beat; then input 1 sends 0xB0..0xB3 -> outputs pair (A0,B0)..(A3,B3).
REQ-035 Back-pressure: data_out_ready=0 for 10 cycles with both inputs valid -> exactly 4 beats are accepted per input, outputs hold 0x0001 stable, then release drains in order.
REQ-036 Full plus pop: both buffers full and data_out_ready=1 with inputs valid -> input ready is 0 in the pop cycle and 1 in the next cycle; count never exceeds 4.
REQ-037 Wrap-around: 20 random-gap beats per branch with random ready -> the output sequence matches a scoreboard and the pointers wrap with no loss or duplication.
REQ-038 Reset mid-stream: rst pulsed with 3 beats buffered -> the next cycle shows valid=0, data_out_*=0 and readys=1, and post-reset beats pair correctly.
